// File: rtl/float_add_pipe.sv
// Two-stage pipelined adder for unsigned {E, M} floats (value = M * 2^E), saturating to all ones.
// Define FLOAT_ADD_SAT_EN to add the sat flag and the saturating sat_count output.
module float_add_pipe #(
  parameter  int EXP_W  = 3,
  parameter  int MANT_W = 5,
  localparam int W      = EXP_W + MANT_W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a_in,
  input  logic [W-1:0] b_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] result
`ifdef FLOAT_ADD_SAT_EN
  ,
  output logic         sat,
  output logic [7:0]   sat_count
`endif
);

  localparam logic [31:0] MANT_W_U = 32'(MANT_W);

  // Pipeline control
  logic r_s1_valid;
  logic r_s2_valid;
  logic w_s2_load;
  logic w_s1_adv;
  logic w_in_fire;

  assign w_s2_load = !r_s2_valid || out_ready;
  assign w_s1_adv  = r_s1_valid && w_s2_load;
  assign in_ready  = !r_s1_valid || w_s1_adv;
  assign w_in_fire = in_valid && in_ready;
  assign out_valid = r_s2_valid;

  // NOTE: every clocked block uses non-blocking (<=) assignments so all
  // registers sample pre-edge values and simulation matches the netlist.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_s1_valid <= 1'b0;
      r_s2_valid <= 1'b0;
    end else begin
      if (w_in_fire)     r_s1_valid <= 1'b1;
      else if (w_s1_adv) r_s1_valid <= 1'b0;
      if (w_s2_load)     r_s2_valid <= r_s1_valid;
    end
  end

  // Stage 1: pick the larger exponent (A wins ties) and align the other mantissa
  logic [EXP_W-1:0]  w_a_e, w_b_e, w_e_large, w_e_small, w_diff;
  logic [MANT_W-1:0] w_a_m, w_b_m, w_m_large, w_m_small, w_m_aligned;
  logic              w_a_larger;
  logic              w_force;

  assign w_a_e      = a_in[W-1:MANT_W];
  assign w_a_m      = a_in[MANT_W-1:0];
  assign w_b_e      = b_in[W-1:MANT_W];
  assign w_b_m      = b_in[MANT_W-1:0];
  assign w_a_larger = (w_a_e >= w_b_e);
  assign w_e_large  = w_a_larger ? w_a_e : w_b_e;
  assign w_e_small  = w_a_larger ? w_b_e : w_a_e;
  assign w_m_large  = w_a_larger ? w_a_m : w_b_m;
  assign w_m_small  = w_a_larger ? w_b_m : w_a_m;
  assign w_diff     = w_e_large - w_e_small;
  assign w_force    = (a_in == {W{1'b1}}) || (b_in == {W{1'b1}});

  // NOTE: combinational blocks assign a default first so no path can infer a latch.
  always_comb begin
    w_m_aligned = '0;
    if (32'(w_diff) < MANT_W_U) w_m_aligned = w_m_small >> w_diff;
  end

  logic [EXP_W-1:0]  r_s1_e;
  logic [MANT_W-1:0] r_s1_m_large;
  logic [MANT_W-1:0] r_s1_m_small;
  logic              r_s1_force;

  // NOTE: datapath registers carry no reset; the valid bits alone qualify them.
  always_ff @(posedge clk) begin
    if (w_in_fire) begin
      r_s1_e       <= w_e_large;
      r_s1_m_large <= w_m_large;
      r_s1_m_small <= w_m_aligned;
      r_s1_force   <= w_force;
    end
  end

  // Stage 2: add, renormalise a carry by one place, saturate on overflow
  logic [MANT_W:0]  w_sum;
  logic             w_carry;
  logic [EXP_W-1:0] w_e_inc;
  logic             w_sat_next;
  logic [W-1:0]     w_result_next;

  assign w_sum      = {1'b0, r_s1_m_large} + {1'b0, r_s1_m_small};
  assign w_carry    = w_sum[MANT_W];
  assign w_e_inc    = r_s1_e + EXP_W'(1);
  assign w_sat_next = r_s1_force || (w_carry && (r_s1_e == {EXP_W{1'b1}}));

  always_comb begin
    w_result_next = {r_s1_e, w_sum[MANT_W-1:0]};
    if (w_sat_next)   w_result_next = {W{1'b1}};
    else if (w_carry) w_result_next = {w_e_inc, w_sum[MANT_W:1]};
  end

  logic [W-1:0] r_result;
  assign result = r_result;

`ifdef FLOAT_ADD_SAT_EN
  logic       r_sat;
  logic [7:0] r_sat_count;
  logic       w_out_fire;

  assign sat        = r_sat;
  assign sat_count  = r_sat_count;
  assign w_out_fire = r_s2_valid && out_ready;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_result <= '0;
`ifdef FLOAT_ADD_SAT_EN
      r_sat    <= 1'b0;
`endif
    end else if (w_s1_adv) begin
      r_result <= w_result_next;
`ifdef FLOAT_ADD_SAT_EN
      r_sat    <= w_sat_next;
`endif
    end
  end

`ifdef FLOAT_ADD_SAT_EN
  // Counts delivered saturated results only, sticking at 255
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sat_count <= '0;
    end else if (w_out_fire && r_sat && (r_sat_count != 8'hFF)) begin
      r_sat_count <= r_sat_count + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_float_add_pipe.sv
// Scoreboard bench for float_add_pipe: directed arithmetic, streaming, backpressure, reset.
// Sat checks are compiled in only when FLOAT_ADD_SAT_EN is defined.
module tb_float_add_pipe;

  localparam int EXP_W  = 3;
  localparam int MANT_W = 5;
  localparam int W      = EXP_W + MANT_W;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a_in;
  logic [W-1:0] b_in;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
`ifdef FLOAT_ADD_SAT_EN
  logic         sat;
  logic [7:0]   sat_count;
`endif

  always #5 clk = ~clk;

  float_add_pipe #(.EXP_W(EXP_W), .MANT_W(MANT_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a_in      (a_in),
    .b_in      (b_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result)
`ifdef FLOAT_ADD_SAT_EN
    ,
    .sat       (sat),
    .sat_count (sat_count)
`endif
  );

  typedef struct packed {
    logic [W-1:0] res;
    logic         sat;
  } exp_t;

  exp_t         sb[$];
  exp_t         mon_e;
  exp_t         e0;
  int           total = 0;
  int           bad = 0;
  int           n_in = 0;
  int           n_out = 0;
  int           exp_sat_cnt = 0;
  logic         s_rdy;
  logic         s_ov;
  logic [W-1:0] s_res;
  logic [W-1:0] ra, rb;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Reference arithmetic worked out on plain integers
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b);
    int   ea, ma, eb, mb, el, ml, es, ms, d, s;
    exp_t r;
    ea = int'(a) >> MANT_W;  ma = int'(a) % (1 << MANT_W);
    eb = int'(b) >> MANT_W;  mb = int'(b) % (1 << MANT_W);
    if (ea >= eb) begin el = ea; ml = ma; es = eb; ms = mb; end
    else          begin el = eb; ml = mb; es = ea; ms = ma; end
    d  = el - es;
    ms = (d >= MANT_W) ? 0 : (ms >> d);
    s  = ml + ms;
    r.sat = 1'b0;
    if (a == {W{1'b1}} || b == {W{1'b1}}) r.sat = 1'b1;
    else if (s >= (1 << MANT_W) && el == (1 << EXP_W) - 1) r.sat = 1'b1;
    if (r.sat)                   r.res = {W{1'b1}};
    else if (s >= (1 << MANT_W)) r.res = W'(((el + 1) << MANT_W) | (s >> 1));
    else                         r.res = W'((el << MANT_W) | s);
    return r;
  endfunction

  // Output side of the scoreboard: every delivered result must match the oldest expectation
  always @(negedge clk) begin
    if (reset === 1'b0 && out_valid === 1'b1 && out_ready === 1'b1) begin
      if (sb.size() == 0) begin
        check("unexpected_out", 32'(out_valid), 32'd0);
      end else begin
        mon_e = sb.pop_front();
        check("result", 32'(result), 32'(mon_e.res));
`ifdef FLOAT_ADD_SAT_EN
        check("sat", 32'(sat), 32'(mon_e.sat));
`endif
        if (mon_e.sat && exp_sat_cnt < 255) exp_sat_cnt++;
        n_out++;
      end
    end
  end

  // One clock cycle: drive at posedge+1, sample at negedge, record accepted operands
  task automatic cyc(input logic v, input logic [W-1:0] a, input logic [W-1:0] b,
                     input logic ordy = 1'b1, input logic dir = 1'b0,
                     input logic [W-1:0] xr = '0, input logic xs = 1'b0);
    in_valid  = v;
    a_in      = a;
    b_in      = b;
    out_ready = ordy;
    @(negedge clk);
    s_rdy = in_ready;
    s_ov  = out_valid;
    s_res = result;
    if (v && in_ready) begin
      sb.push_back(dir ? exp_t'{res: xr, sat: xs} : model(a, b));
      n_in++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string tag);
    int k;
    k = 0;
    while (sb.size() != 0 && k < 50) begin
      cyc(1'b0, '0, '0);
      k++;
    end
    check(tag, 32'(sb.size()), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1; a_in = '0; b_in = '0;
    @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_result", 32'(result), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
`ifdef FLOAT_ADD_SAT_EN
    check("rst_sat", 32'(sat), 32'd0);
    check("rst_sat_count", 32'(sat_count), 32'd0);
`endif
    @(posedge clk);
    #1 reset = 1'b0;
    cyc(1'b0, '0, '0);
    check("idle_in_ready", 32'(s_rdy), 32'd1);
    check("idle_out_valid", 32'(s_ov), 32'd0);

    // Latency: driven in cycle c, result visible in cycle c+2 only
    cyc(1'b1, 8'h10, 8'h10, 1'b1, 1'b1, 8'h30, 1'b0);
    check("lat_rdy", 32'(s_rdy), 32'd1);
    check("lat_c0", 32'(s_ov), 32'd0);
    cyc(1'b0, '0, '0);
    check("lat_c1", 32'(s_ov), 32'd0);
    cyc(1'b0, '0, '0);
    check("lat_c2", 32'(s_ov), 32'd1);
    cyc(1'b0, '0, '0);
    check("lat_c3", 32'(s_ov), 32'd0);

    // Directed arithmetic, saturation and alignment boundaries, back to back
    cyc(1'b1, 8'h90, 8'h30, 1'b1, 1'b1, 8'h92, 1'b0);
    cyc(1'b1, 8'h94, 8'h74, 1'b1, 1'b1, 8'h9E, 1'b0);
    cyc(1'b1, 8'hFE, 8'hFE, 1'b1, 1'b1, 8'hFF, 1'b1);
    cyc(1'b1, 8'hF0, 8'hF0, 1'b1, 1'b1, 8'hFF, 1'b1);
    cyc(1'b1, 8'hF0, 8'hD0, 1'b1, 1'b1, 8'hF8, 1'b0);
    cyc(1'b1, 8'h01, 8'h01, 1'b1, 1'b1, 8'h02, 1'b0);
    cyc(1'b1, 8'hE1, 8'h5F, 1'b1, 1'b1, 8'hE1, 1'b0);
    cyc(1'b1, 8'hC0, 8'h50, 1'b1, 1'b1, 8'hC1, 1'b0);
    cyc(1'b1, 8'h30, 8'hD0, 1'b1, 1'b1, 8'hD0, 1'b0);
    drain("drain_directed");
`ifdef FLOAT_ADD_SAT_EN
    check("sat_count_directed", 32'(sat_count), 32'(exp_sat_cnt));
`endif

    // Full-rate stream of 8: results on 8 consecutive cycles starting 2 later
    for (int i = 0; i < 10; i++) begin
      cyc(i < 8, W'($urandom), W'($urandom));
      if (i < 8) check("stream_rdy", 32'(s_rdy), 32'd1);
      check("stream_ov", 32'(s_ov), 32'(i >= 2));
    end
    drain("drain_stream");
    check("stream_count", 32'(n_out), 32'(n_in));

    // Backpressure: out_ready low for 5 cycles
    for (int i = 0; i < 10; i++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      if (i == 0) e0 = model(ra, rb);
      cyc(i < 8, ra, rb, !(i < 5));
      if (i < 2) check("bp_rdy_open", 32'(s_rdy), 32'd1);
      if (i >= 2 && i < 5) begin
        check("bp_rdy_full", 32'(s_rdy), 32'd0);
        check("bp_ov_hold", 32'(s_ov), 32'd1);
        check("bp_res_hold", 32'(s_res), 32'(e0.res));
      end
    end
    drain("drain_bp");
    check("bp_count", 32'(n_out), 32'(n_in));

    // Asynchronous reset with both stages full, mid-cycle
    cyc(1'b1, 8'h21, 8'h22, 1'b0);
    cyc(1'b1, 8'h43, 8'h44, 1'b0);
    #2;
    reset = 1'b1;
    in_valid = 1'b0;
    #1;
    check("arst_out_valid", 32'(out_valid), 32'd0);
    check("arst_result", 32'(result), 32'd0);
    check("arst_in_ready", 32'(in_ready), 32'd1);
`ifdef FLOAT_ADD_SAT_EN
    check("arst_sat", 32'(sat), 32'd0);
    check("arst_sat_count", 32'(sat_count), 32'd0);
`endif
    sb.delete();
    n_in = 0;
    n_out = 0;
    exp_sat_cnt = 0;
    @(posedge clk);
    #1 reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cyc(1'b0, '0, '0);
      check("post_rst_ov", 32'(s_ov), 32'd0);
      check("post_rst_rdy", 32'(s_rdy), 32'd1);
    end

    // 300 saturating adds: counter tracks exactly, then sticks at 255
    for (int i = 0; i < 100; i++) cyc(1'b1, 8'hFF, W'($urandom));
    drain("drain_sat100");
`ifdef FLOAT_ADD_SAT_EN
    check("sat_count_100", 32'(sat_count), 32'd100);
`endif
    for (int i = 0; i < 200; i++) cyc(1'b1, W'($urandom), 8'hFF);
    drain("drain_sat300");
    check("sat_stream_count", 32'(n_out), 32'd300);
`ifdef FLOAT_ADD_SAT_EN
    check("sat_count_cap", 32'(sat_count), 32'd255);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
